ternary_cam_array: RTL and testbench
====================================

TERNARY_CAM_ARRAY -- requirements
Module: ternary_cam_array

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, key/entry bit width (>=1).
REQ-002 SHALL provide parameter DEPTH, default 16, number of entries (power of 2, >=2).
REQ-003 SHALL provide derived parameter AW, default $clog2(DEPTH), address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low (rst=0 sampled at rising clk resets).
REQ-006 wr_en  in  1  write entry wr_addr this cycle.
REQ-007 wr_addr  in  AW  write target entry.
REQ-008 wr_data  in  WIDTH  stored key bits.
REQ-009 wr_mask  in  WIDTH  per-bit don't-care; 1 = bit ignored in compare.
REQ-010 inv_en  in  1  invalidate entry inv_addr this cycle.
REQ-011 inv_addr  in  AW  invalidate target entry.
REQ-012 srch_valid  in  1  search request this cycle.
REQ-013 srch_key  in  WIDTH  search key.
REQ-014 match_valid  out  1  search result valid.
REQ-015 match_hit  out  1  at least one entry matched.
REQ-016 match_addr  out  AW  lowest-index matching entry.
REQ-017 match_multi  out  1  two or more entries matched.
REQ-018 match_vec  out  DEPTH  per-entry match flags, bit i = entry i.
REQ-019 valid_count  out  AW+1  number of valid entries (0..DEPTH).

Function
REQ-020 Each entry SHALL hold data[WIDTH], mask[WIDTH], valid bit.
REQ-021 Write: wr_en=1 at edge -> entry wr_addr gets data=wr_data, mask=wr_mask, valid=1.
REQ-022 Invalidate: inv_en=1 at edge -> entry inv_addr valid=0; data/mask unchanged.
REQ-023 wr_en and inv_en same cycle, same address -> invalidate wins; entry valid=0, data/mask still written.
REQ-024 wr_en and inv_en same cycle, different addresses -> both take effect.
REQ-025 Entry i matches iff valid_i=1 and for every bit b: mask_i[b]=1 or data_i[b]=srch_key[b].
REQ-026 Entry with mask all ones and valid=1 SHALL match every key.
REQ-027 Search pipeline: stage 1 registers match_vec; stage 2 registers hit/addr/multi from stage-1 vector.
REQ-028 srch_valid=1 at edge N -> match_valid=1 after edge N+2, for exactly one cycle per request.
REQ-029 Fully pipelined: one search accepted per cycle, back-to-back, no stall, no ready signal.
REQ-030 match_vec SHALL be delayed one stage to align with match_valid/hit/addr/multi.
REQ-031 Search at edge N compares against contents as they were before edge N (writes/invalidates at edge N not visible).
REQ-032 Priority: match_addr = lowest index with match_vec bit set; 0 when match_hit=0.
REQ-033 match_multi=1 iff popcount(match_vec)>=2.
REQ-034 When match_valid=0, match_hit, match_multi, match_addr, match_vec SHALL be 0.
REQ-035 valid_count SHALL be +1 on 0->1 valid transition, -1 on 1->0; net of both ops in same cycle; unchanged for write to valid entry or invalidate of invalid entry.
REQ-036 valid_count SHALL never exceed DEPTH nor go below 0.

Reset
REQ-037 rst=0 at edge SHALL clear all valid bits, data, masks, both pipeline stages; valid_count=0.
REQ-038 During/after reset all outputs SHALL be 0; searches in flight are discarded (no match_valid).
REQ-039 wr_en, inv_en, srch_valid SHALL be ignored in any cycle with rst=0.
REQ-040 First search accepted on first edge with rst=1 SHALL produce match_valid two edges later.

Verification (WIDTH=8, DEPTH=16)
REQ-041 Reset, search key 8'hA5 -> match_valid=1 at N+2, hit=0, addr=0, multi=0, valid_count=0.
REQ-042 Write e3 data 8'hA0 mask 8'h0F, e7 data 8'hA5 mask 8'h00; search 8'hA5 -> hit=1, addr=3, multi=1, match_vec=16'h0088, valid_count=2.
REQ-043 Same cycle: write e5 data 8'h11 mask 0 and search 8'h11 -> hit=0; search next cycle -> hit=1, addr=5.
REQ-044 Same cycle wr_en and inv_en both addr 9 -> e9 invalid, valid_count unchanged from prior invalid state; search of written key -> miss.
REQ-045 Fill all 16 entries, rewrite e0 -> valid_count=16; invalidate e15 twice -> valid_count=15.
REQ-046 Issue 3 back-to-back searches, assert rst=0 on cycle 2 -> no match_valid pulses, all entries cleared.

Source files
------------

// File: rtl/ternary_cam_array.sv
// rtl/ternary_cam_array.sv - ternary CAM array with pipelined priority search
//
// Purpose: DEPTH entries of {data, mask, valid}. A search compares the key
// against every valid entry in parallel (mask bit 1 = don't care) and reports
// the per-entry match vector, hit, lowest matching index and multi-hit flag.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   wr_en/addr/data/mask write one entry (sets valid)
//   inv_en/inv_addr     invalidate one entry (data/mask kept)
//   srch_valid/srch_key search request, one per cycle, no backpressure
//   match_valid         result strobe, two edges after the request edge
//   match_hit/addr/multi/vec  result fields, all zero when match_valid=0
//   valid_count         number of valid entries, 0..DEPTH
module ternary_cam_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             inv_en,
    input  logic [AW-1:0]    inv_addr,
    input  logic             srch_valid,
    input  logic [WIDTH-1:0] srch_key,
    output logic             match_valid,
    output logic             match_hit,
    output logic [AW-1:0]    match_addr,
    output logic             match_multi,
    output logic [DEPTH-1:0] match_vec,
    output logic [AW:0]      valid_count
);

    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [WIDTH-1:0] ent_mask [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [AW:0]      count_q;

    // Entry storage. Invalidate overrides the valid bit of a same-address
    // write, but the write still lands in data/mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_data[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    ent_data[i] <= wr_data;
                    ent_mask[i] <= wr_mask;
                end
                if (inv_en && (inv_addr == AW'(i)))
                    ent_valid[i] <= 1'b0;
                else if (wr_en && (wr_addr == AW'(i)))
                    ent_valid[i] <= 1'b1;
            end
        end
    end

    // Count only real valid transitions: a write raises the count only when
    // it targets an invalid entry not simultaneously invalidated, and an
    // invalidate lowers it only when the entry is currently valid.
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        cnt_inc = wr_en && !ent_valid[wr_addr] && !(inv_en && (inv_addr == wr_addr));
        cnt_dec = inv_en && ent_valid[inv_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end

    assign valid_count = count_q;

    // Parallel compare against the contents held before this edge.
    logic [DEPTH-1:0] cmp_vec;

    always_comb begin
        cmp_vec = '0;
        for (int i = 0; i < DEPTH; i++)
            cmp_vec[i] = ent_valid[i] &&
                         (((ent_data[i] ^ srch_key) & ~ent_mask[i]) == '0);
    end

    // Stage 1: registered match vector.
    logic             s1_valid;
    logic [DEPTH-1:0] s1_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else begin
            s1_valid <= srch_valid;
            s1_vec   <= srch_valid ? cmp_vec : '0;
        end
    end

    // Lowest-index priority encode plus multi-hit detect.
    logic          enc_hit;
    logic [AW-1:0] enc_addr;
    logic          enc_multi;

    always_comb begin
        enc_hit   = 1'b0;
        enc_addr  = '0;
        enc_multi = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s1_vec[i]) begin
                if (enc_hit) begin
                    enc_multi = 1'b1;
                end else begin
                    enc_hit  = 1'b1;
                    enc_addr = AW'(i);
                end
            end
        end
    end

    // Stage 2: encoded result with the vector carried alongside.
    logic             s2_valid;
    logic             s2_hit;
    logic [AW-1:0]    s2_addr;
    logic             s2_multi;
    logic [DEPTH-1:0] s2_vec;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            s2_addr  <= '0;
            s2_multi <= 1'b0;
            s2_vec   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hit   <= s1_valid && enc_hit;
            s2_addr  <= s1_valid ? enc_addr : '0;
            s2_multi <= s1_valid && enc_multi;
            s2_vec   <= s1_valid ? s1_vec : '0;
        end
    end

    // Result register so the strobe appears two edges after the request edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_valid <= 1'b0;
            match_hit   <= 1'b0;
            match_addr  <= '0;
            match_multi <= 1'b0;
            match_vec   <= '0;
        end else begin
            match_valid <= s2_valid;
            match_hit   <= s2_hit;
            match_addr  <= s2_addr;
            match_multi <= s2_multi;
            match_vec   <= s2_vec;
        end
    end

endmodule

// File: tb/tb_ternary_cam_array.sv
// tb/tb_ternary_cam_array.sv - scoreboard bench for ternary_cam_array
module tb_ternary_cam_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  wr_mask;
    logic        inv_en;
    logic [3:0]  inv_addr;
    logic        srch_valid;
    logic [7:0]  srch_key;
    logic        match_valid;
    logic        match_hit;
    logic [3:0]  match_addr;
    logic        match_multi;
    logic [15:0] match_vec;
    logic [4:0]  valid_count;

    ternary_cam_array #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .inv_en(inv_en), .inv_addr(inv_addr),
        .srch_valid(srch_valid), .srch_key(srch_key),
        .match_valid(match_valid), .match_hit(match_hit), .match_addr(match_addr),
        .match_multi(match_multi), .match_vec(match_vec), .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [3:0]  addr;
        logic        multi;
        logic [15:0] vec;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result strobe; idle outputs must be 0.
    always @(negedge clk) begin
        if (match_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_match_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_hit"},   int'(match_hit),   int'(e.hit));
                chk({e.name, "_addr"},  int'(match_addr),  int'(e.addr));
                chk({e.name, "_multi"}, int'(match_multi), int'(e.multi));
                chk({e.name, "_vec"},   int'(match_vec),   int'(e.vec));
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end else begin
            chk("idle_outputs_zero",
                int'({match_hit, match_multi, match_addr, match_vec}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        inv_en = 1'b0;
        srch_valid = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
    endtask

    task automatic inv(input logic [3:0] a);
        inv_en = 1'b1;
        inv_addr = a;
    endtask

    // Request issued for the next edge; result expected after two more edges.
    task automatic srch(input string name, input logic [7:0] key, input logic hit,
                        input logic [3:0] addr, input logic multi, input logic [15:0] vec);
        exp_t e;
        srch_valid = 1'b1;
        srch_key = key;
        e.hit = hit;
        e.addr = addr;
        e.multi = multi;
        e.vec = vec;
        e.cyc = cyc + 3;
        e.name = name;
        exp_q.push_back(e);
    endtask

    initial begin
        int pulses_before;
        rst = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        inv_en = 1'b0; inv_addr = '0;
        srch_valid = 1'b0; srch_key = '0;
        repeat (3) tick();
        chk("reset_valid_count", int'(valid_count), 0);
        chk("reset_match_valid", int'(match_valid), 0);

        // First search on the first edge out of reset: empty array misses.
        rst = 1'b1;
        srch("empty_a5", 8'hA5, 1'b0, 4'd0, 1'b0, 16'h0000);
        tick();
        chk("empty_count", int'(valid_count), 0);

        wr(4'd3, 8'hA0, 8'h0F); tick();
        wr(4'd7, 8'hA5, 8'h00); tick();
        srch("a5_two_hits", 8'hA5, 1'b1, 4'd3, 1'b1, 16'h0088); tick();
        chk("count_after_two", int'(valid_count), 2);

        // Write and search in the same cycle: new entry not yet visible.
        wr(4'd5, 8'h11, 8'h00);
        srch("same_cycle_miss", 8'h11, 1'b0, 4'd0, 1'b0, 16'h0000); tick();
        srch("next_cycle_hit", 8'h11, 1'b1, 4'd5, 1'b0, 16'h0020); tick();
        chk("count_after_e5", int'(valid_count), 3);

        // Write and invalidate the same address: invalidate wins.
        wr(4'd9, 8'h3C, 8'h00); inv(4'd9); tick();
        chk("count_same_addr", int'(valid_count), 3);
        srch("e9_invalid_miss", 8'h3C, 1'b0, 4'd0, 1'b0, 16'h0000); tick();

        // Write and invalidate different addresses: both apply.
        wr(4'd9, 8'h3C, 8'h00); inv(4'd5); tick();
        chk("count_diff_addr", int'(valid_count), 3);
        srch("e9_hit", 8'h3C, 1'b1, 4'd9, 1'b0, 16'h0200); tick();
        srch("e5_gone", 8'h11, 1'b0, 4'd0, 1'b0, 16'h0000); tick();

        // Fully masked entry matches any key; invalidating an invalid entry is a no-op.
        wr(4'd12, 8'h00, 8'hFF); tick();
        srch("wildcard", 8'h77, 1'b1, 4'd12, 1'b0, 16'h1000); tick();
        inv(4'd5); tick();
        chk("count_inv_invalid", int'(valid_count), 4);

        // Fill every entry, then rewrite e0 as a wildcard.
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 8'(i), 8'h00);
            tick();
        end
        chk("count_full", int'(valid_count), 16);
        wr(4'd0, 8'h00, 8'hFF); tick();
        chk("count_rewrite", int'(valid_count), 16);
        srch("low_priority", 8'h05, 1'b1, 4'd0, 1'b1, 16'h0021); tick();

        inv(4'd15);
        srch("pre_inv_e15", 8'h0F, 1'b1, 4'd0, 1'b1, 16'h8001); tick();
        chk("count_inv15", int'(valid_count), 15);
        inv(4'd15);
        srch("post_inv_e15", 8'h0F, 1'b1, 4'd0, 1'b0, 16'h0001); tick();
        chk("count_inv15_again", int'(valid_count), 15);

        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 0);

        // Reset with searches in flight: nothing may emerge.
        pulses_before = pulses;
        srch_valid = 1'b1; srch_key = 8'h05; tick();
        rst = 1'b0; srch_valid = 1'b1; srch_key = 8'h05; tick();
        rst = 1'b0; srch_valid = 1'b1; srch_key = 8'h05; tick();
        rst = 1'b1;
        repeat (4) tick();
        chk("no_pulse_after_reset", pulses - pulses_before, 0);
        chk("count_after_reset", int'(valid_count), 0);
        srch("cleared_05", 8'h05, 1'b0, 4'd0, 1'b0, 16'h0000); tick();
        srch("cleared_00", 8'h00, 1'b0, 4'd0, 1'b0, 16'h0000); tick();

        repeat (5) tick();
        chk("final_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
